// File: rtl/seg7_scan.sv
// Four-digit common-anode 7-segment scanner: latches a 16-bit hex value and lights one
// digit at a time, with an all-off gap between digits and optional leading-zero blanking.
module seg7_scan #(
   parameter int SCAN_DIV    = 100000,
   parameter int GAP_CYCLES  = 16,
   parameter int LZ_SUPPRESS = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic        sel_hi,
   input  logic [31:0] wdata,
   output logic [6:0]  cathodes,
   output logic [3:0]  AN
);

   localparam int MAX_C = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
   localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;
   localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   typedef enum logic {GAP = 1'b0, SHOW = 1'b1} state_t;

   state_t           state_r;
   logic [15:0]      disp_r;
   logic [1:0]       idx_r;
   logic [CNT_W-1:0] cnt_r;
   logic [3:0]       nib_s;
   logic             blank_s;

   // Active-low {g,f,e,d,c,b,a} hex glyphs.
   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] seg;
      case (v)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         4'hF:    seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   // Display latch and scan sequencer; loads never touch the scan position.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_r  <= 16'h0000;
         state_r <= GAP;
         idx_r   <= 2'd0;
         cnt_r   <= '0;
      end else begin
         if (we) begin
            disp_r <= sel_hi ? wdata[31:16] : wdata[15:0];
         end
         case (state_r)
            GAP: begin
               if (cnt_r == GAP_LAST) begin
                  cnt_r   <= '0;
                  state_r <= SHOW;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            SHOW: begin
               if (cnt_r == SHOW_LAST) begin
                  cnt_r   <= '0;
                  state_r <= GAP;
                  idx_r   <= idx_r + 2'd1;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            default: begin
               cnt_r   <= '0;
               state_r <= GAP;
            end
         endcase
      end
   end

   // Digit nibble select and leading-zero test: digit k is blank when everything at and above it is zero.
   always_comb begin
      nib_s   = 4'h0;
      blank_s = 1'b0;
      case (idx_r)
         2'd0: begin
            nib_s   = disp_r[3:0];
            blank_s = 1'b0;
         end
         2'd1: begin
            nib_s   = disp_r[7:4];
            blank_s = (disp_r[15:4] == 12'h000);
         end
         2'd2: begin
            nib_s   = disp_r[11:8];
            blank_s = (disp_r[15:8] == 8'h00);
         end
         2'd3: begin
            nib_s   = disp_r[15:12];
            blank_s = (disp_r[15:12] == 4'h0);
         end
         default: begin
            nib_s   = 4'h0;
            blank_s = 1'b0;
         end
      endcase
   end

   // Pin decode from registered state only.
   always_comb begin
      AN       = 4'b1111;
      cathodes = 7'b1111111;
      if (state_r == SHOW) begin
         AN = ~(4'b0001 << idx_r);
         if ((LZ_SUPPRESS != 0) && blank_s) begin
            cathodes = 7'b1111111;
         end else begin
            cathodes = hex7(nib_s);
         end
      end else begin
         AN       = 4'b1111;
         cathodes = 7'b1111111;
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized bench for seg7_scan: two instances (with and without leading-zero blanking)
// compared every cycle against a slot/phase arithmetic model of the display.
module tb_seg7_scan;

   localparam int SCAN = 4;
   localparam int GAP  = 1;
   localparam int PER  = SCAN + GAP;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic        sel_hi = 1'b0;
   logic [31:0] wdata = 32'h0;
   logic [6:0]  cath0, cath1;
   logic [3:0]  an0, an1;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          t = 0;
   logic [15:0] mdisp = 16'h0;
   logic [6:0]  seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   seg7_scan #(.SCAN_DIV(SCAN), .GAP_CYCLES(GAP), .LZ_SUPPRESS(0)) dut (
      .clk(clk), .rst(rst), .we(we), .sel_hi(sel_hi), .wdata(wdata),
      .cathodes(cath0), .AN(an0));

   seg7_scan #(.SCAN_DIV(SCAN), .GAP_CYCLES(GAP), .LZ_SUPPRESS(1)) dut_lz (
      .clk(clk), .rst(rst), .we(we), .sel_hi(sel_hi), .wdata(wdata),
      .cathodes(cath1), .AN(an1));

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [10:0] got, input logic [10:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s t=%0d disp=%h got AN/cath=%b_%b want %b_%b",
                  tag, t, mdisp, got[10:7], got[6:0], want[10:7], want[6:0]);
      end
   endtask

   // Expected {AN, cathodes} t cycles after reset release with value d latched.
   function automatic logic [10:0] exp_out(input int tc, input logic [15:0] d, input bit lz);
      int         ph;
      int         k;
      logic [15:0] upper;
      logic [3:0]  an;
      logic [6:0]  cat;
      ph = tc % PER;
      k  = (tc / PER) % 4;
      if (ph < GAP) return 11'h7FF;
      upper = d >> (4 * k);
      an    = ~(4'b0001 << k);
      if (lz && k > 0 && upper == 16'h0) cat = 7'h7F;
      else cat = seg_tab[upper[3:0]];
      return {an, cat};
   endfunction

   task automatic check_outs();
      check_val("scan", {an0, cath0}, exp_out(t, mdisp, 1'b0));
      check_val("scan_lz", {an1, cath1}, exp_out(t, mdisp, 1'b1));
   endtask

   // One clock: drive inputs, model the edge, check at the following falling edge.
   task automatic step(input logic w, input logic s, input logic [31:0] d);
      we = w; sel_hi = s; wdata = d;
      @(posedge clk);
      if (w) mdisp = s ? d[31:16] : d[15:0];
      t++;
      @(negedge clk);
      we = 1'b0;
      check_outs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
   endtask

   // Idle until the model is inside the lit slot of digit k at phase ph.
   task automatic goto_slot(input int k, input int ph);
      for (int i = 0; i < 4 * PER && !(((t / PER) % 4) == k && (t % PER) == ph); i++)
         step(1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] d;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_val("rst_blank", {an0, cath0}, 11'h7FF);
      check_val("rst_blank_lz", {an1, cath1}, 11'h7FF);
      rst = 1'b0; t = 0; mdisp = 16'h0;
      #1 check_outs();
      idle(12);

      step(1'b1, 1'b0, 32'h0000_A5F3);
      idle(22);
      step(1'b1, 1'b1, 32'h1234_FFFF);
      idle(22);

      goto_slot(2, 2);
      step(1'b1, 1'b0, 32'h0000_8888);
      idle(22);

      step(1'b1, 1'b0, 32'h0000_0040);
      idle(22);
      step(1'b1, 1'b0, 32'h0000_0000);
      idle(22);

      step(1'b1, 1'b0, 32'h0000_1111);
      step(1'b1, 1'b1, 32'h0B0C_0000);
      step(1'b1, 1'b0, 32'h0000_00E0);
      idle(22);

      for (int i = 0; i < 800; i++) begin
         r = $urandom;
         d = $urandom;
         for (int n = 0; n < 8; n++)
            if (r[8 + n]) d[4*n +: 4] = 4'h0;
         step(r[2:0] == 3'b000, r[3], d);
      end

      step(1'b1, 1'b0, 32'h0000_9D7C);
      goto_slot(3, 2);
      #2 rst = 1'b1;
      #1 check_val("async_rst", {an0, cath0}, 11'h7FF);
      check_val("async_rst_lz", {an1, cath1}, 11'h7FF);
      we = 1'b1; sel_hi = 1'b0; wdata = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      check_val("rst_hold", {an0, cath0}, 11'h7FF);
      we = 1'b0;
      rst = 1'b0; t = 0; mdisp = 16'h0;
      #1 check_outs();
      idle(25);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
